// File: rtl/gpio_pattern_gen_if.sv
// Pin-side bundle of the GPIO pattern generator: raw button/hold inputs and
// the pattern, step pulse and status outputs.
interface gpio_pattern_gen_if #(
    parameter int N_CH = 26
);
    logic            mode_btn;
    logic            hold;
    logic [N_CH-1:0] out;
    logic            tick;
    logic [1:0]      mode;
    logic [7:0]      led;

    modport master (output mode_btn, hold, input out, tick, mode, led);
    modport slave  (input mode_btn, hold, output out, tick, mode, led);
endinterface

// File: rtl/gpio_pattern_gen.sv
// GPIO pattern generator for board bring-up: drives N_CH pins with one of four
// test patterns selected by a debounced mode button, stepped at clk/STEP_DIV.
module gpio_pattern_gen #(
    parameter int N_CH     = 26,
    parameter int STEP_DIV = 25,
    parameter int DEB_CYC  = 250000
) (
    input  logic              clk_25mhz,
    input  logic              rst_n,
    gpio_pattern_gen_if.slave io
);
    localparam int ID_W  = $clog2(N_CH);
    localparam int POS_W = $clog2(ID_W + 2);
    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int DEB_W = $clog2(DEB_CYC);

    typedef enum logic [1:0] {
        ALL_TOGGLE = 2'd0,
        WALK_ONE   = 2'd1,
        ALT_PHASE  = 2'd2,
        ID_SERIAL  = 2'd3
    } mode_t;

    logic             btn_p0, btn_s, hold_p0, hold_s;
    logic             btn_d, btn_d_q;
    logic [DEB_W-1:0] deb_cnt;
    mode_t            mode_q, mode_nxt;
    logic             mode_chg;
    logic [DIV_W-1:0] div;
    logic             tick_q, phase;
    logic [ID_W-1:0]  walk;
    logic [POS_W-1:0] pos;
    logic [N_CH-1:0]  out_q, out_nxt;

    // Stage p0 -> s: two-flop synchronisers for the raw board inputs
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            btn_p0  <= 1'b0;
            btn_s   <= 1'b0;
            hold_p0 <= 1'b0;
            hold_s  <= 1'b0;
        end else begin
            btn_p0  <= io.mode_btn;
            btn_s   <= btn_p0;
            hold_p0 <= io.hold;
            hold_s  <= hold_p0;
        end
    end

    // Debounce: btn_d follows btn_s only after DEB_CYC consecutive mismatches
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            btn_d   <= 1'b0;
            btn_d_q <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_d_q <= btn_d;
            if (btn_s == btn_d) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                btn_d   <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign mode_chg = btn_d & ~btn_d_q;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) mode_q <= ALL_TOGGLE;
        else        mode_q <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode_q;
        if (mode_chg) begin
            case (mode_q)
                ALL_TOGGLE: mode_nxt = WALK_ONE;
                WALK_ONE:   mode_nxt = ALT_PHASE;
                ALT_PHASE:  mode_nxt = ID_SERIAL;
                ID_SERIAL:  mode_nxt = ALL_TOGGLE;
                default:    mode_nxt = ALL_TOGGLE;
            endcase
        end
    end

    // Step divider and step state; a mode change overrides a coincident tick
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            tick_q <= 1'b0;
            phase  <= 1'b0;
            walk   <= '0;
            pos    <= '0;
        end else begin
            tick_q <= ~hold_s & ~mode_chg & (div == DIV_W'(STEP_DIV - 1));
            if (mode_chg) begin
                div <= '0;
            end else if (!hold_s) begin
                div <= (div == DIV_W'(STEP_DIV - 1)) ? '0 : div + DIV_W'(1);
            end

            if (mode_chg) begin
                phase <= 1'b0;
                walk  <= '0;
                pos   <= '0;
            end else if (tick_q) begin
                phase <= ~phase;
                walk  <= (walk == ID_W'(N_CH - 1)) ? '0 : walk + ID_W'(1);
                pos   <= (pos == POS_W'(ID_W + 1)) ? '0 : pos + POS_W'(1);
            end
        end
    end

    // ID frame per channel is {start=1, channel id MSB first, stop=0}
    always_comb begin
        logic [ID_W+1:0] frame;
        frame   = '0;
        out_nxt = '0;
        case (mode_q)
            ALL_TOGGLE: out_nxt = {N_CH{phase}};
            WALK_ONE:   out_nxt = N_CH'(1) << walk;
            ALT_PHASE: begin
                for (int c = 0; c < N_CH; c++) begin
                    out_nxt[c] = (c % 2 == 0) ? phase : ~phase;
                end
            end
            ID_SERIAL: begin
                for (int c = 0; c < N_CH; c++) begin
                    frame      = {1'b1, ID_W'(c), 1'b0} << pos;
                    out_nxt[c] = frame[ID_W+1];
                end
            end
            default:    out_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_nxt;
    end

    assign io.out  = out_q;
    assign io.tick = tick_q;
    assign io.mode = mode_q;
    assign io.led  = {4'h0, hold_s, phase, mode_q};

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Bench for gpio_pattern_gen: directed bring-up scenarios plus random button/hold
// activity, all compared cycle by cycle against a step-count based reference.
module tb_gpio_pattern_gen;
    localparam int N_CH     = 6;
    localparam int STEP_DIV = 4;
    localparam int DEB_CYC  = 8;
    localparam int ID_W     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    gpio_pattern_gen_if #(.N_CH(N_CH)) io();

    gpio_pattern_gen #(
        .N_CH    (N_CH),
        .STEP_DIV(STEP_DIV),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .clk_25mhz(clk),
        .rst_n    (rst_n),
        .io       (io)
    );

    always #5 clk = ~clk;

    // Reference state: pipeline of raw inputs, debounced level, and counts of
    // un-held cycles and completed steps since the last mode change.
    bit              m_b1, m_bs, m_h1, m_hs, m_bd, m_bdq, m_tick;
    int              m_run, m_mode, m_active, m_steps;
    logic [N_CH-1:0] m_out;

    function automatic logic [N_CH-1:0] pattern(input int md, input int k);
        logic [N_CH-1:0] p;
        int fp;
        bit ph;
        p  = '0;
        ph = (k % 2) == 1;
        fp = k % (ID_W + 2);
        case (md)
            0: p = ph ? {N_CH{1'b1}} : {N_CH{1'b0}};
            1: p[k % N_CH] = 1'b1;
            2: for (int c = 0; c < N_CH; c++) p[c] = (c % 2 == 0) ? ph : !ph;
            default: begin
                for (int c = 0; c < N_CH; c++) begin
                    if (fp == 0)             p[c] = 1'b1;
                    else if (fp == ID_W + 1) p[c] = 1'b0;
                    else                     p[c] = ((c >> (ID_W - fp)) & 1) == 1;
                end
            end
        endcase
        return p;
    endfunction

    task automatic model_reset();
        m_b1 = 0; m_bs = 0; m_h1 = 0; m_hs = 0; m_bd = 0; m_bdq = 0; m_tick = 0;
        m_run = 0; m_mode = 0; m_active = 0; m_steps = 0; m_out = '0;
    endtask

    task automatic model_step(input bit btn, input bit hld);
        bit chg;
        chg   = m_bd && !m_bdq;
        m_out = pattern(m_mode, m_steps);
        if (chg) m_steps = 0;
        else if (m_tick) m_steps++;
        m_tick = !m_hs && !chg && (m_active % STEP_DIV == STEP_DIV - 1);
        if (chg) begin
            m_active = 0;
            m_mode   = (m_mode + 1) % 4;
        end else if (!m_hs) begin
            m_active++;
        end
        m_bdq = m_bd;
        if (m_bs != m_bd) begin
            m_run++;
            if (m_run == DEB_CYC) begin
                m_bd  = m_bs;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_hs = m_h1; m_h1 = hld;
        m_bs = m_b1; m_b1 = btn;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic run_cycle(input bit btn, input bit hld);
        logic [7:0] exp_led;
        io.mode_btn = btn;
        io.hold     = hld;
        model_step(btn, hld);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        exp_led = {4'h0, m_hs, m_steps[0], m_mode[1:0]};
        check("out",  32'(io.out),  32'(m_out));
        check("tick", 32'(io.tick), 32'(m_tick));
        check("mode", 32'(io.mode), 32'(m_mode));
        check("led",  32'(io.led),  32'(exp_led));
    endtask

    task automatic press();
        repeat (12) run_cycle(1'b1, 1'b0);
        repeat (14) run_cycle(1'b0, 1'b0);
    endtask

    initial begin
        int glitch_len[3];
        glitch_len  = '{3, 5, 7};
        io.mode_btn = 1'b0;
        io.hold     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out",  32'(io.out),  32'h0);
        check("rst_tick", 32'(io.tick), 32'h0);
        check("rst_mode", 32'(io.mode), 32'h0);
        check("rst_led",  32'(io.led),  32'h0);
        rst_n = 1'b1;

        // ALL_TOGGLE from reset
        repeat (24) run_cycle(1'b0, 1'b0);

        // Clean 12-cycle press: mode changes exactly 11 cycles after it starts
        for (int i = 1; i <= 12; i++) begin
            run_cycle(1'b1, 1'b0);
            if (i == 10) check("press_mode_early", 32'(io.mode), 32'd0);
            if (i == 11) check("press_mode",       32'(io.mode), 32'd1);
        end
        repeat (30) run_cycle(1'b0, 1'b0);

        // Bounces shorter than the debounce window
        foreach (glitch_len[g]) begin
            repeat (glitch_len[g]) run_cycle(1'b1, 1'b0);
            repeat (2) run_cycle(1'b0, 1'b0);
        end
        repeat (12) run_cycle(1'b0, 1'b0);
        check("glitch_mode", 32'(io.mode), 32'd1);

        // ALT_PHASE with hold raised mid-period
        press();
        repeat (6) run_cycle(1'b0, 1'b0);
        repeat (10) run_cycle(1'b0, 1'b1);
        repeat (12) run_cycle(1'b0, 1'b0);

        // ID_SERIAL frames, then asynchronous reset between clock edges
        press();
        repeat (30) run_cycle(1'b0, 1'b0);
        check("id_mode", 32'(io.mode), 32'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_out",  32'(io.out),  32'h0);
        check("async_mode", 32'(io.mode), 32'h0);
        check("async_led",  32'(io.led),  32'h0);
        check("async_tick", 32'(io.tick), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) run_cycle(1'b0, 1'b0);

        // Random button levels (presses and bounces) and hold activity
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            bit b, h;
            len = $urandom_range(1, 24);
            b   = $urandom_range(0, 1) == 1;
            h   = $urandom_range(0, 3) == 0;
            repeat (len) run_cycle(b, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
